// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage types and constants, plus the codebase-wide defines
// (BASE_ADDRESS, NOP_INST, MEM_READ, MEM_WIDTH_W) used by the fetch front end.
`ifndef BASE_ADDRESS
`define BASE_ADDRESS 32'h0000_0000
`endif
`ifndef NOP_INST
`define NOP_INST 32'h0000_0000
`endif
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WIDTH_W
`define MEM_WIDTH_W 2'b10
`endif

package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] NopInst = `NOP_INST;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of {pc, inst} entries with push/pop/flush and an occupancy count.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Payload storage needs no reset; count/pointers gate its visibility.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  // The issue rule reserves a slot for every in-flight word.
  assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: streams sequential PCs to imem and queues (pc, inst) pairs for decode.
// Optional FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
`ifndef BASE_ADDRESS
`define BASE_ADDRESS 32'h0000_0000
`endif

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = `BASE_ADDRESS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_inst
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          kill;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Issue only when the FIFO can absorb every word already requested.
  assign imem_req  = !reset && !redirect_valid && !full &&
                     ((int'(count) + int'(inflight)) < int'(DEPTH));
  assign imem_addr = fetch_pc;

  assign push       = inflight && !kill && !redirect_valid;
  assign push_entry = '{pc: inflight_pc, inst: imem_data};
  assign pop        = dec_valid && dec_ready;

  assign dec_valid = !empty;
  assign dec_pc    = dec_valid ? head.pc : 32'h0000_0000;
  assign dec_inst  = dec_valid ? head.inst : NopInst;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= word_align(RESET_PC);
      inflight_pc <= '0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
    end else begin
      inflight <= imem_req;
      kill     <= redirect_valid;
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
      end else if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] flush_drop;

  // A head popped in the redirect cycle was consumed, not discarded.
  assign flush_drop = 32'(count) - 32'(pop) + 32'(inflight && !kill);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (push) stat_fetched <= stat_fetched + 32'd1;
      if (redirect_valid) stat_flushed <= stat_flushed + flush_drop;
    end
  end
`endif

endmodule
